// File: rtl/dmac_pkg.sv
// Shared constants, FSM state encoding and job descriptor for the DMA channel scheduler.
package dmac_pkg;

  localparam int N_CH_DEF   = 4;
  localparam int JCNT_W_DEF = 16;
  localparam int ADDR_W     = 32;
  localparam int LEN_W      = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_CPL
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [LEN_W-1:0]  len;
  } job_cfg_t;

endpackage

// File: rtl/dmac_rr_arbiter.sv
// Combinational round-robin picker: searches upward from the channel after `last`,
// returning a one-hot grant, its index, and whether any channel was requesting.
module dmac_rr_arbiter
  import dmac_pkg::*;
#(
  parameter int N_CH = N_CH_DEF
) (
  input  logic [N_CH-1:0]         req,
  input  logic [$clog2(N_CH)-1:0] last,
  output logic [N_CH-1:0]         grant,
  output logic [$clog2(N_CH)-1:0] idx,
  output logic                    valid
);

  localparam int IDX_W = $clog2(N_CH);

  always_comb begin
    int c;
    // NOTE: every output gets a value before the search loop, so no latch can be inferred.
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    c     = 0;
    for (int k = 1; k <= N_CH; k++) begin
      c = (int'(last) + k) % N_CH;
      if (!valid && req[c]) begin
        valid    = 1'b1;
        grant[c] = 1'b1;
        idx      = IDX_W'(c);
      end
    end
  end

endmodule

// File: rtl/dmac_ch_sched.sv
// Multi-channel job scheduler in front of a single DMA engine: round-robin grant,
// config latch, start pulse, completion wait and per-channel done pulse.
module dmac_ch_sched
  import dmac_pkg::*;
#(
  parameter int N_CH   = N_CH_DEF,
  parameter int JCNT_W = JCNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_CH-1:0]          req_i,
  input  logic [N_CH*ADDR_W-1:0]   src_addr_i,
  input  logic [N_CH*ADDR_W-1:0]   dst_addr_i,
  input  logic [N_CH*LEN_W-1:0]    byte_len_i,
  output logic [N_CH-1:0]          ack_o,
  output logic [N_CH-1:0]          done_o,
  output logic [ADDR_W-1:0]        eng_src_addr_o,
  output logic [ADDR_W-1:0]        eng_dst_addr_o,
  output logic [LEN_W-1:0]         eng_byte_len_o,
  output logic                     eng_start_o,
  input  logic                     eng_done_i,
  input  logic                     eng_idle_i,
  output logic                     busy_o,
  output logic [$clog2(N_CH)-1:0]  cur_ch_o,
  output logic [JCNT_W-1:0]        job_cnt_o
);

  localparam int IDX_W = $clog2(N_CH);

  state_t            state, state_nxt;
  job_cfg_t          cfg_q, cfg_sel;
  logic [IDX_W-1:0]  cur_ch_q, last_q, arb_idx;
  logic [N_CH-1:0]   arb_grant;
  logic              arb_valid, grant_en;
  logic [JCNT_W-1:0] job_cnt_q;

  dmac_rr_arbiter #(.N_CH(N_CH)) u_arb (
    .req   (req_i),
    .last  (last_q),
    .grant (arb_grant),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  always_comb begin
    cfg_sel.src = src_addr_i[int'(arb_idx)*ADDR_W +: ADDR_W];
    cfg_sel.dst = dst_addr_i[int'(arb_idx)*ADDR_W +: ADDR_W];
    cfg_sel.len = byte_len_i[int'(arb_idx)*LEN_W +: LEN_W];
  end

  always_comb begin
    state_nxt   = state;
    grant_en    = 1'b0;
    ack_o       = '0;
    eng_start_o = 1'b0;
    done_o      = '0;
    case (state)
      S_IDLE: begin
        // ack is combinational, so it must be held off while reset is asserted
        if (rst_n && arb_valid && eng_idle_i) begin
          grant_en  = 1'b1;
          ack_o     = arb_grant;
          state_nxt = (cfg_sel.len != '0) ? S_START : S_CPL;
        end
      end
      S_START: begin
        eng_start_o = 1'b1;
        state_nxt   = S_WAIT;
      end
      S_WAIT: begin
        if (eng_done_i) state_nxt = S_CPL;
      end
      S_CPL: begin
        done_o[cur_ch_q] = 1'b1;
        state_nxt        = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: the latched config drives the engine ports directly, so it is reset to keep them at 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg_q     <= '0;
      cur_ch_q  <= '0;
      last_q    <= IDX_W'(N_CH - 1);
      job_cnt_q <= '0;
    end else begin
      if (grant_en) begin
        cfg_q    <= cfg_sel;
        cur_ch_q <= arb_idx;
        last_q   <= arb_idx;
      end
      if (state == S_CPL) job_cnt_q <= job_cnt_q + JCNT_W'(1);
    end
  end

  assign busy_o         = (state != S_IDLE);
  assign cur_ch_o       = busy_o ? cur_ch_q : '0;
  assign eng_src_addr_o = cfg_q.src;
  assign eng_dst_addr_o = cfg_q.dst;
  assign eng_byte_len_o = cfg_q.len;
  assign job_cnt_o      = job_cnt_q;

endmodule

// File: tb/tb_dmac_ch_sched.sv
// Self-checking bench for dmac_ch_sched: directed sequences, a per-cycle vector table,
// and randomized traffic against a timestamp-based transaction model.
module tb_dmac_ch_sched;

  localparam int NC = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NC-1:0]   req;
  logic [31:0]     src [NC];
  logic [31:0]     dst [NC];
  logic [31:0]     len [NC];
  logic [NC*32-1:0] src_flat, dst_flat, len_flat;
  logic [NC-1:0]   ack_o, done_o;
  logic [31:0]     eng_src, eng_dst, eng_len;
  logic            eng_start, eng_done, eng_idle, busy_o;
  logic [1:0]      cur_ch_o;
  logic [15:0]     job_cnt_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    src_flat = '0;
    dst_flat = '0;
    len_flat = '0;
    for (int i = 0; i < NC; i++) begin
      src_flat[i*32 +: 32] = src[i];
      dst_flat[i*32 +: 32] = dst[i];
      len_flat[i*32 +: 32] = len[i];
    end
  end

  dmac_ch_sched #(.N_CH(NC), .JCNT_W(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_i          (req),
    .src_addr_i     (src_flat),
    .dst_addr_i     (dst_flat),
    .byte_len_i     (len_flat),
    .ack_o          (ack_o),
    .done_o         (done_o),
    .eng_src_addr_o (eng_src),
    .eng_dst_addr_o (eng_dst),
    .eng_byte_len_o (eng_len),
    .eng_start_o    (eng_start),
    .eng_done_i     (eng_done),
    .eng_idle_i     (eng_idle),
    .busy_o         (busy_o),
    .cur_ch_o       (cur_ch_o),
    .job_cnt_o      (job_cnt_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string pfx);
    check({pfx, "_ack"},   64'(ack_o),     64'd0);
    check({pfx, "_done"},  64'(done_o),    64'd0);
    check({pfx, "_start"}, 64'(eng_start), 64'd0);
    check({pfx, "_busy"},  64'(busy_o),    64'd0);
    check({pfx, "_cur"},   64'(cur_ch_o),  64'd0);
    check({pfx, "_src"},   64'(eng_src),   64'd0);
    check({pfx, "_dst"},   64'(eng_dst),   64'd0);
    check({pfx, "_len"},   64'(eng_len),   64'd0);
    check({pfx, "_jcnt"},  64'(job_cnt_o), 64'd0);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    req      = '0;
    eng_done = 1'b0;
    eng_idle = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check_quiet("rst");
    next_cycle();
    rst_n = 1'b1;
  endtask

  // Round-robin choice from the rules: first requester after the last grant, circularly.
  function automatic int pick_rr(input logic [NC-1:0] r, input int last);
    for (int k = 1; k <= NC; k++) begin
      if (r[(last + k) % NC]) return (last + k) % NC;
    end
    return -1;
  endfunction

  typedef struct {
    logic [3:0]  req;
    logic        idle;
    logic        dn;
    logic [3:0]  ack;
    logic        start;
    logic [3:0]  done;
    logic        busy;
    logic [1:0]  cur;
    logic [15:0] jcnt;
  } vec_t;

  vec_t tbl [17];

  // random-phase model state
  int          m_last, m_ch, m_cnt, grant_at, start_at, done_at, g;
  bit          m_active;
  logic [31:0] m_src, m_dst, m_len;
  logic [NC-1:0] exp_ack, exp_done, clr;
  logic        exp_start, exp_busy;

  initial begin
    rst_n    = 1'b0;
    req      = '0;
    eng_done = 1'b0;
    eng_idle = 1'b1;
    for (int i = 0; i < NC; i++) begin
      src[i] = '0;
      dst[i] = '0;
      len[i] = '0;
    end

    // ---- single job on ch2 with engine latency ----
    do_reset();
    src[2] = 32'h1000; dst[2] = 32'h8000; len[2] = 32'h2000;
    req = 4'b0100;
    @(negedge clk);
    check("a_ack", 64'(ack_o), 64'h4);
    check("a_nostart", 64'(eng_start), 64'd0);
    next_cycle();
    req = '0;
    @(negedge clk);
    check("a_start", 64'(eng_start), 64'd1);
    check("a_src", 64'(eng_src), 64'h1000);
    check("a_dst", 64'(eng_dst), 64'h8000);
    check("a_len", 64'(eng_len), 64'h2000);
    check("a_ack_once", 64'(ack_o), 64'd0);
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("a_wait_done", 64'(done_o), 64'd0);
      check("a_wait_start", 64'(eng_start), 64'd0);
      next_cycle();
    end
    eng_done = 1'b1;
    @(negedge clk);
    check("a_done_early", 64'(done_o), 64'd0);
    next_cycle();
    eng_done = 1'b0;
    @(negedge clk);
    check("a_done", 64'(done_o), 64'h4);
    check("a_cpl_src", 64'(eng_src), 64'h1000);
    check("a_jcnt0", 64'(job_cnt_o), 64'd0);
    next_cycle();
    @(negedge clk);
    check("a_jcnt1", 64'(job_cnt_o), 64'd1);
    check("a_idle", 64'(busy_o), 64'd0);
    check("a_done_once", 64'(done_o), 64'd0);

    // ---- reset in the middle of a wait; next grant must be ch0 ----
    next_cycle();
    src[1] = 32'h2222; dst[1] = 32'h3333; len[1] = 32'h40;
    req = 4'b0010;
    @(negedge clk);
    check("b_ack", 64'(ack_o), 64'h2);
    next_cycle();
    req = '0;
    next_cycle();
    @(negedge clk);
    check("b_busy", 64'(busy_o), 64'd1);
    check("b_cur", 64'(cur_ch_o), 64'd1);
    next_cycle();
    rst_n    = 1'b0;
    req      = 4'b1111;
    eng_done = 1'b1;
    next_cycle();
    check_quiet("b_rst");
    eng_done = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    check("b_ch0_first", 64'(ack_o), 64'h1);
    check("b_no_done", 64'(done_o), 64'd0);
    next_cycle();

    // ---- per-cycle vector table: round-robin order, len=0, idle gating, spurious done ----
    do_reset();
    for (int i = 0; i < NC; i++) begin
      src[i] = 32'h100 * (i + 1);
      dst[i] = 32'h9000 + 32'h10 * i;
    end
    len[0] = 32'd4; len[1] = 32'd0; len[2] = 32'd8; len[3] = 32'd16;
    //            req      idle  dn    ack      st    done     busy  cur   jcnt
    tbl[0]  = '{4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 16'd0};
    tbl[1]  = '{4'b1111, 1'b1, 1'b1, 4'b0001, 1'b0, 4'b0000, 1'b0, 2'd0, 16'd0};
    tbl[2]  = '{4'b1110, 1'b1, 1'b1, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, 16'd0};
    tbl[3]  = '{4'b1110, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd0, 16'd0};
    tbl[4]  = '{4'b1110, 1'b1, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd0, 16'd0};
    tbl[5]  = '{4'b1110, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0001, 1'b1, 2'd0, 16'd0};
    tbl[6]  = '{4'b1110, 1'b1, 1'b0, 4'b0010, 1'b0, 4'b0000, 1'b0, 2'd0, 16'd1};
    tbl[7]  = '{4'b1100, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0010, 1'b1, 2'd1, 16'd1};
    tbl[8]  = '{4'b1100, 1'b1, 1'b0, 4'b0100, 1'b0, 4'b0000, 1'b0, 2'd0, 16'd2};
    tbl[9]  = '{4'b1000, 1'b1, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2, 16'd2};
    tbl[10] = '{4'b1000, 1'b1, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd2, 16'd2};
    tbl[11] = '{4'b1000, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0100, 1'b1, 2'd2, 16'd2};
    tbl[12] = '{4'b1000, 1'b1, 1'b0, 4'b1000, 1'b0, 4'b0000, 1'b0, 2'd0, 16'd3};
    tbl[13] = '{4'b0001, 1'b1, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd3, 16'd3};
    tbl[14] = '{4'b0001, 1'b1, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd3, 16'd3};
    tbl[15] = '{4'b0001, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b1000, 1'b1, 2'd3, 16'd3};
    tbl[16] = '{4'b0001, 1'b1, 1'b0, 4'b0001, 1'b0, 4'b0000, 1'b0, 2'd0, 16'd4};
    for (int r = 0; r < 17; r++) begin
      req      = tbl[r].req;
      eng_idle = tbl[r].idle;
      eng_done = tbl[r].dn;
      @(negedge clk);
      check($sformatf("t%0d_ack", r),   64'(ack_o),     64'(tbl[r].ack));
      check($sformatf("t%0d_start", r), 64'(eng_start), 64'(tbl[r].start));
      check($sformatf("t%0d_done", r),  64'(done_o),    64'(tbl[r].done));
      check($sformatf("t%0d_busy", r),  64'(busy_o),    64'(tbl[r].busy));
      check($sformatf("t%0d_cur", r),   64'(cur_ch_o),  64'(tbl[r].cur));
      check($sformatf("t%0d_jcnt", r),  64'(job_cnt_o), 64'(tbl[r].jcnt));
      if (tbl[r].start) begin
        check($sformatf("t%0d_elen", r), 64'(eng_len), 64'(len[tbl[r].cur]));
        check($sformatf("t%0d_esrc", r), 64'(eng_src), 64'(src[tbl[r].cur]));
      end
      next_cycle();
    end

    // ---- randomized traffic against the transaction model ----
    do_reset();
    m_last = NC - 1; m_ch = 0; m_cnt = 0; m_active = 1'b0;
    grant_at = -1; start_at = -1; done_at = -1;
    m_src = '0; m_dst = '0; m_len = '0;
    clr = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int c = 0; c < NC; c++) begin
        if (clr[c]) begin
          req[c] = 1'b0;
        end else if (!req[c]) begin
          if ($urandom_range(3) == 0) begin
            src[c] = $urandom;
            dst[c] = $urandom;
            len[c] = ($urandom_range(3) == 0) ? 32'd0 : $urandom;
            req[c] = 1'b1;
          end
        end else if ($urandom_range(19) == 0) begin
          req[c] = 1'b0;
        end
      end
      clr      = '0;
      eng_idle = ($urandom_range(3) != 0);
      eng_done = ($urandom_range(2) == 0);
      @(negedge clk);

      exp_ack   = '0;
      exp_done  = '0;
      exp_start = (cyc == start_at);
      exp_busy  = m_active && (cyc > grant_at);
      if (m_active && cyc == done_at) exp_done[m_ch] = 1'b1;
      g = -1;
      if (!m_active && eng_idle) g = pick_rr(req, m_last);
      if (g >= 0) exp_ack[g] = 1'b1;

      check("r_ack",   64'(ack_o),     64'(exp_ack));
      check("r_start", 64'(eng_start), 64'(exp_start));
      check("r_done",  64'(done_o),    64'(exp_done));
      check("r_busy",  64'(busy_o),    64'(exp_busy));
      check("r_cur",   64'(cur_ch_o),  exp_busy ? 64'(m_ch) : 64'd0);
      check("r_jcnt",  64'(job_cnt_o), 64'(16'(m_cnt)));
      if (exp_busy) begin
        check("r_esrc", 64'(eng_src), 64'(m_src));
        check("r_edst", 64'(eng_dst), 64'(m_dst));
        check("r_elen", 64'(eng_len), 64'(m_len));
      end

      if (exp_done != '0) begin
        m_active = 1'b0;
        m_cnt++;
      end else if (g >= 0) begin
        m_active = 1'b1;
        m_ch     = g;
        m_last   = g;
        grant_at = cyc;
        m_src    = src[g];
        m_dst    = dst[g];
        m_len    = len[g];
        if (m_len == 0) begin
          start_at = -1;
          done_at  = cyc + 1;
        end else begin
          start_at = cyc + 1;
          done_at  = -1;
        end
        if ($urandom_range(3) != 0) clr[g] = 1'b1;
      end else if (m_active && done_at < 0 && start_at >= 0 && cyc > start_at && eng_done) begin
        done_at = cyc + 1;
      end
      next_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
